// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: write/read request streams, read responses and the SRAM-side port of the arbiter.
interface sram_access_arbiter_if #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 18,
    parameter int WFIFO_DEPTH = 8
);
    logic                           wr_valid;
    logic                           wr_ready;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           rd_valid;
    logic                           rd_ready;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic                           rd_data_valid;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic [$clog2(WFIFO_DEPTH):0]   wfifo_level;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [DATA_WIDTH-1:0]          mem_wdata;
    logic                           mem_we;
    logic [DATA_WIDTH-1:0]          mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
        input  wr_ready, rd_ready, rd_data_valid, rd_data, wfifo_level, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
        output wr_ready, rd_ready, rd_data_valid, rd_data, wfifo_level, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: read-priority scheduler merging a buffered write stream and an in-order read stream onto one SRAM port.
module sram_access_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 18,
    parameter int READ_LATENCY = 2,
    parameter int WFIFO_DEPTH  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_access_arbiter_if.slave bus
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [ADDR_WIDTH-1:0]   fifo_addr_q [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_q [WFIFO_DEPTH];
    logic [PW-1:0]           wptr_q, rptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic [READ_LATENCY:0]   tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    mem_we_q, mem_we_d;
    logic                    rd_data_valid_q, rd_data_valid_d;
    logic                    full, empty, push, pop;
    logic [1:0]              op;

    // Only registered state and rd_valid feed the decision; wr_valid never reaches wr_ready.
    assign full    = level_q == LW'(WFIFO_DEPTH);
    assign empty   = level_q == '0;
    assign push    = bus.wr_valid && !full;
    assign op      = full ? OP_WRITE : bus.rd_valid ? OP_READ : !empty ? OP_WRITE : OP_IDLE;
    assign pop     = op == OP_WRITE;
    assign level_d = level_q + LW'(push) - LW'(pop);

    always_comb begin
        mem_addr_d      = op == OP_READ ? bus.rd_addr : op == OP_WRITE ? fifo_addr_q[rptr_q] : mem_addr_q;
        mem_wdata_d     = op == OP_WRITE ? fifo_data_q[rptr_q] : mem_wdata_q;
        mem_we_d        = pop;
        tag_d           = {tag_q[READ_LATENCY-1:0], op == OP_READ};
        rd_data_valid_d = tag_q[READ_LATENCY];
        rd_data_d       = tag_q[READ_LATENCY] ? bus.mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            level_q         <= '0;
            tag_q           <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            wptr_q          <= wptr_q + PW'(push);
            rptr_q          <= rptr_q + PW'(pop);
            level_q         <= level_d;
            tag_q           <= tag_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= bus.wr_addr;
            fifo_data_q[wptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready      = !full;
    assign bus.rd_ready      = bus.rd_valid && !full;
    assign bus.wfifo_level   = level_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_data       = rd_data_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed bench with read/write scoreboards and a latency-2 SRAM model.
module tb_sram_access_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0, failures = 0, cyc = 0;
    int rd_pulses = 0, rd_first = 0, rd_last = 0;
    int we_pulses = 0, we_first = 0, we_last = 0;
    logic [17:0] rq[$];
    int rc[$];
    logic [37:0] wq[$];
    logic [17:0] ref_mem [256];
    logic [17:0] sram [256];
    logic [17:0] s1;
    logic preloaded = 1'b0;

    sram_access_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(18), .WFIFO_DEPTH(8)) b ();

    sram_access_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(18), .READ_LATENCY(2), .WFIFO_DEPTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(b)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pat(input int i);
        return 18'(i * 311) ^ 18'h2C00;
    endfunction

    // SRAM model: mem_rdata holds the addressed word two edges after mem_addr is driven.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) sram[i] <= pat(i);
            preloaded <= 1'b1;
        end else if (b.mem_we) sram[b.mem_addr[7:0]] <= b.mem_wdata;
        s1 <= sram[b.mem_addr[7:0]];
        b.mem_rdata <= s1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        b.wr_valid = 1'b0;
        b.wr_addr  = '0;
        b.wr_data  = '0;
        b.rd_valid = 1'b0;
        b.rd_addr  = '0;
    endtask

    task automatic tick();
        logic [17:0] d;
        logic [37:0] w;
        int c;
        @(negedge clk);
        if (rst_n) begin
            if (b.wr_valid && b.wr_ready) begin
                wq.push_back({b.wr_addr, b.wr_data});
                ref_mem[b.wr_addr[7:0]] = b.wr_data;
            end
            if (b.rd_valid && b.rd_ready) begin
                rq.push_back(ref_mem[b.rd_addr[7:0]]);
                rc.push_back(cyc + 4);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (b.rd_data_valid) begin
            if (rd_pulses == 0) rd_first = cyc;
            rd_last = cyc;
            rd_pulses++;
            if (rq.size() == 0) check("rd_spurious", b.rd_data_valid, 0);
            else begin
                d = rq.pop_front();
                c = rc.pop_front();
                check("rd_data", b.rd_data, d);
                check("rd_latency", cyc, c);
            end
        end
        if (b.mem_we) begin
            if (we_pulses == 0) we_first = cyc;
            we_last = cyc;
            we_pulses++;
            if (wq.size() == 0) check("we_spurious", b.mem_we, 0);
            else begin
                w = wq.pop_front();
                check("wr_issue", {b.mem_addr, b.mem_wdata}, w);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        // Reset held while inputs toggle
        for (int k = 0; k < 4; k++) begin
            b.wr_valid = 1'($urandom);
            b.wr_addr  = 20'($urandom);
            b.wr_data  = 18'($urandom);
            b.rd_valid = 1'($urandom);
            b.rd_addr  = 20'($urandom);
            tick();
            check("rst_mem_we", b.mem_we, 0);
            check("rst_mem_addr", b.mem_addr, 0);
            check("rst_mem_wdata", b.mem_wdata, 0);
            check("rst_rd_valid", b.rd_data_valid, 0);
            check("rst_rd_data", b.rd_data, 0);
            check("rst_level", b.wfifo_level, 0);
            check("rst_wr_ready", b.wr_ready, 1);
        end
        clr();
        rst_n = 1'b1;
        tick();
        // First write after release
        b.wr_valid = 1'b1; b.wr_addr = 20'h00010; b.wr_data = 18'h01234;
        tick();
        clr();
        check("w0_mem_we", b.mem_we, 0);
        check("w0_level", b.wfifo_level, 1);
        tick();
        check("w1_mem_we", b.mem_we, 1);
        tick();
        check("w2_mem_we", b.mem_we, 0);
        check("w2_level", b.wfifo_level, 0);
        // Single write then read of the same word
        b.wr_valid = 1'b1; b.wr_addr = 20'h00005; b.wr_data = 18'h2A5A5;
        tick();
        clr();
        repeat (3) tick();
        b.rd_valid = 1'b1; b.rd_addr = 20'h00005;
        #1;
        check("single_rd_ready", b.rd_ready, 1);
        rd_pulses = 0;
        tick();
        clr();
        repeat (5) tick();
        check("single_rd_pulses", rd_pulses, 1);
        check("single_rq_empty", rq.size(), 0);
        // Read burst 0..15 with seven concurrent writes
        rd_pulses = 0;
        for (int k = 0; k < 16; k++) begin
            b.rd_valid = 1'b1; b.rd_addr = 20'(k);
            b.wr_valid = k < 7; b.wr_addr = 20'(8'h40 + k); b.wr_data = 18'(18'h30000 | k);
            tick();
        end
        check("burst_level7", b.wfifo_level, 7);
        b.wr_valid = 1'b1; b.wr_addr = 20'h00047; b.wr_data = 18'h30007; b.rd_addr = 20'd16;
        tick();
        b.wr_valid = 1'b0;
        check("full_level", b.wfifo_level, 8);
        check("full_wr_ready", b.wr_ready, 0);
        check("full_rd_ready", b.rd_ready, 0);
        tick();
        check("full_mem_we", b.mem_we, 1);
        check("full_mem_addr", b.mem_addr, 20'h00040);
        check("full_pop_level", b.wfifo_level, 7);
        check("after_full_rd_ready", b.rd_ready, 1);
        clr();
        tick();
        check("burst_pulses", rd_pulses, 16);
        check("burst_contiguous", rd_last - rd_first, 15);
        repeat (12) tick();
        check("burst_drained", b.wfifo_level, 0);
        // Simultaneous push/pop at level 3
        b.rd_valid = 1'b1; b.rd_addr = 20'h00020;
        for (int k = 0; k < 3; k++) begin
            b.wr_valid = 1'b1; b.wr_addr = 20'(8'h50 + k); b.wr_data = 18'(18'h15000 + k);
            tick();
        end
        check("pp_level_fill", b.wfifo_level, 3);
        b.rd_valid = 1'b0;
        for (int k = 3; k < 5; k++) begin
            b.wr_addr = 20'(8'h50 + k); b.wr_data = 18'(18'h15000 + k);
            tick();
            check("pp_level_hold", b.wfifo_level, 3);
            check("pp_mem_we", b.mem_we, 1);
        end
        clr();
        repeat (8) tick();
        check("pp_drained", b.wfifo_level, 0);
        for (int k = 0; k < 5; k++) check("pp_sram", sram[8'h50 + k], 18'(18'h15000 + k));
        // FIFO drain with no reads
        we_pulses = 0;
        for (int k = 0; k < 8; k++) begin
            b.wr_valid = 1'b1; b.wr_addr = 20'(8'h60 + k); b.wr_data = 18'(18'h2F000 + k);
            tick();
        end
        clr();
        repeat (4) tick();
        check("drain_we_count", we_pulses, 8);
        check("drain_we_contig", we_last - we_first, 7);
        check("drain_level", b.wfifo_level, 0);
        check("drain_mem_we", b.mem_we, 0);
        // Reset during in-flight reads with four writes queued
        for (int k = 0; k < 4; k++) begin
            b.rd_valid = 1'b1; b.rd_addr = 20'(8'h30 + k);
            b.wr_valid = 1'b1; b.wr_addr = 20'(8'hC0 + k); b.wr_data = 18'(18'h0AB00 + k);
            tick();
        end
        b.wr_valid = 1'b0; b.rd_addr = 20'h00034;
        check("mid_level4", b.wfifo_level, 4);
        tick();
        rst_n = 1'b0;
        rq.delete();
        rc.delete();
        wq.delete();
        clr();
        #1;
        check("mid_rst_level", b.wfifo_level, 0);
        check("mid_rst_valid", b.rd_data_valid, 0);
        check("mid_rst_we", b.mem_we, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid_post_we", b.mem_we, 0);
            check("mid_post_level", b.wfifo_level, 0);
        end
        check("end_rq_empty", rq.size(), 0);
        check("end_wq_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
